// File: rtl/encoder_frontend.sv
// encoder_frontend: synchronizes and deglitches raw A/B/Z encoder pins,
// then decodes clean A/B into 4x step/dir pulses plus index and error events.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_a, in_b, in_z         : raw asynchronous encoder pins
//   a_clean, b_clean, z_clean: filtered levels
//   step, dir                : one-cycle step pulse, direction (1 = B leads)
//   index                    : one-cycle pulse on z_clean rising edge
//   err, err_count           : illegal A/B transition pulse, saturating count
module encoder_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_a,
    input  logic       in_b,
    input  logic       in_z,
    output logic       a_clean,
    output logic       b_clean,
    output logic       z_clean,
    output logic       step,
    output logic       dir,
    output logic       index,
    output logic       err,
    output logic [7:0] err_count
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] FiltLen  = 4'(FILTER_LEN);
    localparam logic [4:0] InitLast = 5'(SYNC_STAGES + FILTER_LEN - 1);

    // Channel order in the per-channel vectors: 0 = A, 1 = B, 2 = Z
    logic [2:0]                  rawPins;
    logic [2:0][SYNC_STAGES-1:0] syncQ;
    logic [2:0]                  syncOut;
    logic [2:0][3:0]             filtCnt;
    logic [2:0]                  cleanQ;

    state_t     stateQ;
    state_t     stateD;
    logic [4:0] initCnt;
    logic       running;

    logic [1:0] prevAb;
    logic [1:0] curAb;
    logic [1:0] abDiff;
    logic       prevZ;
    logic       stepQ;
    logic       dirQ;
    logic       indexQ;
    logic       errQ;
    logic [7:0] errCntQ;

    assign rawPins = {in_z, in_b, in_a};

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            syncOut[ch] = syncQ[ch][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            syncQ <= '0;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                syncQ[ch] <= {syncQ[ch][SYNC_STAGES-2:0], rawPins[ch]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= INIT;
            initCnt <= '0;
        end else begin
            stateQ <= stateD;
            if (stateQ == INIT) begin
                initCnt <= initCnt + 5'd1;
            end
        end
    end

    always_comb begin
        stateD  = stateQ;
        running = 1'b0;
        case (stateQ)
            INIT: begin
                if (initCnt == InitLast) begin
                    stateD = RUN;
                end
            end
            RUN: begin
                running = 1'b1;
            end
            default: stateD = INIT;
        endcase
    end

    // While in INIT the clean levels track the synchronizer directly so
    // that the decoder starts from the real pin state after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cleanQ  <= '0;
            filtCnt <= '0;
        end else if (!running) begin
            cleanQ  <= syncOut;
            filtCnt <= '0;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                if (syncOut[ch] == cleanQ[ch]) begin
                    filtCnt[ch] <= '0;
                end else if (filtCnt[ch] + 4'd1 == FiltLen) begin
                    cleanQ[ch]  <= syncOut[ch];
                    filtCnt[ch] <= '0;
                end else begin
                    filtCnt[ch] <= filtCnt[ch] + 4'd1;
                end
            end
        end
    end

    assign curAb  = {cleanQ[0], cleanQ[1]};
    assign abDiff = prevAb ^ curAb;

    // A single-bit change is a legal step; A_prev ^ B_cur is 0 exactly
    // for the forward (A leads) Gray transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            prevAb  <= '0;
            prevZ   <= 1'b0;
            stepQ   <= 1'b0;
            dirQ    <= 1'b0;
            indexQ  <= 1'b0;
            errQ    <= 1'b0;
            errCntQ <= '0;
        end else if (!running) begin
            prevAb <= {syncOut[0], syncOut[1]};
            prevZ  <= syncOut[2];
            stepQ  <= 1'b0;
            indexQ <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            prevAb <= curAb;
            prevZ  <= cleanQ[2];
            stepQ  <= ^abDiff;
            errQ   <= &abDiff;
            indexQ <= cleanQ[2] & ~prevZ;
            if (^abDiff) begin
                dirQ <= prevAb[1] ^ curAb[0];
            end
            if ((&abDiff) && (errCntQ != 8'hFF)) begin
                errCntQ <= errCntQ + 8'd1;
            end
        end
    end

    assign a_clean   = cleanQ[0];
    assign b_clean   = cleanQ[1];
    assign z_clean   = cleanQ[2];
    assign step      = stepQ;
    assign dir       = dirQ;
    assign index     = indexQ;
    assign err       = errQ;
    assign err_count = errCntQ;

endmodule

// File: doc/encoder_frontend.md
# encoder_frontend

Front-end conditioning and quadrature decode stage that sits directly upstream of the encoder counter. It synchronizes the raw A/B/Z encoder pins into the system clock domain and rejects glitches shorter than a programmable length. It then decodes the cleaned A/B pair into single-cycle step pulses with a direction bit and a one-cycle index pulse, so the downstream counter runs synchronously on clean, qualified events. Illegal quadrature transitions are flagged and counted.

## Interface
- SYNC_STAGES, 2: synchronizer flops per input; legal range 2..4.
- FILTER_LEN, 4: consecutive stable synchronized samples required before a clean output changes; legal range 1..15.

Clocking and reset (already decided): one clock; reset is synchronous and active-high.

- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_a  input  1  raw encoder channel A, asynchronous.
- in_b  input  1  raw encoder channel B, asynchronous.
- in_z  input  1  raw index/zero channel, asynchronous.
- a_clean  output  1  filtered A level.
- b_clean  output  1  filtered B level.
- z_clean  output  1  filtered Z level.
- step  output  1  one-cycle pulse per legal A/B edge (4x decode).
- dir  output  1  direction of the last legal step: 0 = A leads (forward), 1 = B leads (reverse); valid with step, held otherwise.
- index  output  1  one-cycle pulse on each rising edge of z_clean.
- err  output  1  one-cycle pulse when an illegal A/B transition is detected.
- err_count  output  8  count of illegal transitions; saturates at 255.

## Operation
- Per channel: a SYNC_STAGES-deep flop chain produces the synchronized value s.
- Per-channel glitch filter, 4-bit counter:
  - If s equals the clean value, the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter would reach FILTER_LEN, the clean value takes s and the counter clears.
  - A pulse shorter than FILTER_LEN synchronized samples never reaches the clean output.
- FSM with two states, INIT and RUN:
  - INIT: entered on rst. Clean values load directly from s with no step, index or err generation. Leaves for RUN after SYNC_STAGES+FILTER_LEN cycles, so clean values reflect the actual pin levels after reset.
  - RUN: decoding active; stays until rst.
- Decode in RUN compares the registered previous clean AB against the current clean AB.
  - Forward sequence (AB) is 00→10→11→01→00. Each forward transition gives step=1, dir=0.
  - The reverse sequence gives step=1, dir=1.
  - No change gives step=0 and holds dir.
  - Both bits changing on the same edge (00↔11, 10↔01) is illegal: err=1, step=0, dir held, err_count+1 unless it is already 255.
- index=1 for one cycle when z_clean goes 0→1 in RUN. The index pulse is independent of A/B; step and index may assert in the same cycle.
- rst at any time, including mid-filter or mid-pulse, returns the block to INIT and clears all counters and outputs.

## Timing
- Reset values: a_clean, b_clean, z_clean, step, dir, index, err = 0; err_count = 0; filter counters = 0; state = INIT.
- Latency: a raw level change held stable is first sampled at edge k. The clean output changes after edge k+SYNC_STAGES+FILTER_LEN-1. step/dir/index/err assert in the following cycle, one registered stage after the clean change.
- With the defaults this is 5 cycles to the clean output and 6 cycles to step.
- Minimum legal edge spacing is FILTER_LEN+1 cycles per channel. Closer spacing may be filtered out, or may appear as an illegal transition.
- step, index and err are high for exactly one clock per event.

## Test plan
- Reset with in_a=1, in_b=1, in_z=0, defaults: a_clean=b_clean=1 by the end of INIT; no step, index or err ever asserts; err_count=0.
- Forward rotation from AB=00, each level held for 10 cycles, 8 transitions: 8 step pulses, all with dir=0. The first step occurs 6 cycles after the first in_a rise is sampled.
- Reverse rotation, 8 transitions: 8 step pulses with dir=1; dir stays 1 between pulses.
- 3-cycle glitch on in_a with FILTER_LEN=4: a_clean unchanged and no step. A 4-cycle pulse propagates and produces 2 steps (forward, then reverse).
- in_a and in_b toggled on the same cycle from 00 to 11, repeated 300 times: 300 err pulses, no steps, err_count saturates at 255.
- in_z rising 10 cycles after an in_a rise, then rst asserted mid-filter on in_b: one index pulse; after rst all outputs are 0 and the block is in INIT.
